alu_share_arbiter: RTL and testbench

// - Shares the single 32-bit execute ALU between two requesters (0: pipeline EXE stage, 1: address-gen/debug port).
// - Round-robin or fixed-priority grant; valid/ready on requests and on the single response channel.
// - Drives ALU cmd/operands from registers and samples the combinational ALU result and N/Z/C/V.
// - Owns the architectural status register (NZCV) that supplies C_in.

---
 rtl/alu_share_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Lets two requesters share one combinational execute ALU. Requester 0 is the
// pipeline EXE stage and requester 1 is the address-gen/debug port. Each
// accepted operation is held in issue registers for one settle cycle. The ALU
// result and flags are then captured into a response that is held until the
// consumer takes it. The block also owns the architectural NZCV status
// register, which supplies the carry-in of every accepted operation.
module alu_share_arbiter #(
  parameter int DATA_W     = 32,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_cmd,
  input  logic [DATA_W-1:0] req0_val1,
  input  logic [DATA_W-1:0] req0_val2,
  input  logic              req0_s,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_cmd,
  input  logic [DATA_W-1:0] req1_val1,
  input  logic [DATA_W-1:0] req1_val2,
  input  logic              req1_s,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_nzcv,

  output logic [3:0]        alu_cmd,
  output logic [DATA_W-1:0] alu_val1,
  output logic [DATA_W-1:0] alu_val2,
  output logic              alu_c_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,

  output logic [3:0]        sr_nzcv,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e              state_q;
  logic                lastGrant_q;
  logic [3:0]          cmd_q;
  logic [DATA_W-1:0]   val1_q;
  logic [DATA_W-1:0]   val2_q;
  logic                cIn_q;
  logic                s_q;
  logic                id_q;
  logic                rspValid_q;
  logic                rspId_q;
  logic [DATA_W-1:0]   rspResult_q;
  logic [3:0]          rspNzcv_q;
  logic [3:0]          sr_q;

  logic                grantOpp;
  logic                anyValid;
  logic                pick1;
  logic                transfer;
  logic                cmdSupported;
  logic                cmdSetsCv;
  logic [DATA_W-1:0]   rspResult_d;
  logic [3:0]          rspNzcv_d;
  logic [3:0]          sr_d;

  // Arbitration: decide who may hand over an operation this cycle. Ready is gated
  // by rst_n so that nothing looks accepted while the block is held in reset.
  always_comb begin
    grantOpp = rst_n && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    anyValid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      pick1 = PRIO_FIXED ? 1'b0 : ~lastGrant_q;
    end else begin
      pick1 = req1_valid;
    end
    transfer   = grantOpp && anyValid;
    req0_ready = transfer && !pick1;
    req1_ready = transfer && pick1;
  end

  // Decode the issued command into the response and the status-register update.
  // The ALU does not implement unsupported commands. For those, the response
  // reports the current SR and a zero result.
  always_comb begin
    cmdSupported = 1'b0;
    cmdSetsCv    = 1'b0;
    case (cmd_q)
      4'b0001, 4'b0110, 4'b0111, 4'b1000, 4'b1001: cmdSupported = 1'b1;
      4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
        cmdSupported = 1'b1;
        cmdSetsCv    = 1'b1;
      end
      default: cmdSupported = 1'b0;
    endcase

    rspResult_d = '0;
    rspNzcv_d   = sr_q;
    sr_d        = sr_q;
    if (cmdSupported) begin
      rspResult_d = alu_result;
      rspNzcv_d   = {alu_n, alu_z, alu_c, alu_v};
      if (s_q) begin
        sr_d = {alu_n, alu_z,
                cmdSetsCv ? alu_c : sr_q[1],
                cmdSetsCv ? alu_v : sr_q[0]};
      end
    end
  end

  // Main FSM: IDLE -> ISSUE -> RESP -> IDLE/ISSUE. It owns the issue registers,
  // the response registers and the status register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      cmd_q       <= '0;
      val1_q      <= '0;
      val2_q      <= '0;
      cIn_q       <= 1'b0;
      s_q         <= 1'b0;
      id_q        <= 1'b0;
      rspValid_q  <= 1'b0;
      rspId_q     <= 1'b0;
      rspResult_q <= '0;
      rspNzcv_q   <= '0;
      sr_q        <= '0;
    end else begin
      if (transfer) begin
        cmd_q       <= pick1 ? req1_cmd  : req0_cmd;
        val1_q      <= pick1 ? req1_val1 : req0_val1;
        val2_q      <= pick1 ? req1_val2 : req0_val2;
        s_q         <= pick1 ? req1_s    : req0_s;
        id_q        <= pick1;
        cIn_q       <= sr_q[1];
        lastGrant_q <= pick1;
      end
      case (state_q)
        IDLE: begin
          if (transfer) begin
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          rspResult_q <= rspResult_d;
          rspNzcv_q   <= rspNzcv_d;
          rspId_q     <= id_q;
          sr_q        <= sr_d;
          rspValid_q  <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            state_q    <= transfer ? ISSUE : IDLE;
          end
        end
        default: begin
          rspValid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = rspValid_q;
  assign rsp_id     = rspId_q;
  assign rsp_result = rspResult_q;
  assign rsp_nzcv   = rspNzcv_q;
  assign alu_cmd    = cmd_q;
  assign alu_val1   = val1_q;
  assign alu_val2   = val2_q;
  assign alu_c_in   = cIn_q;
  assign sr_nzcv    = sr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// This bench drives the arbiter with directed and random traffic. A behavioural
// ALU is attached to the DUT. Every cycle the outputs are compared against a
// transaction-level model of grants, responses and the status register. A
// second instance built with fixed priority is watched for its priority rule.
module tb_alu_share_arbiter;

  localparam logic [3:0] C_MOV = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_ADC = 4'b0011;
  localparam logic [3:0] C_SUB = 4'b0100;

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req0_ready, req0_s;
  logic [3:0] req0_cmd;
  logic [31:0] req0_val1, req0_val2;
  logic req1_valid, req1_ready, req1_s;
  logic [3:0] req1_cmd;
  logic [31:0] req1_val1, req1_val2;
  logic rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic [3:0] rsp_nzcv, alu_cmd, sr_nzcv;
  logic [31:0] alu_val1, alu_val2, alu_result;
  logic alu_c_in, alu_n, alu_z, alu_c, alu_v, busy;
  logic [35:0] aluOut;

  logic fxReq0Ready, fxReq1Ready, fxRspValid, fxRspId, fxCIn, fxBusy;
  logic [31:0] fxRspResult, fxVal1, fxVal2;
  logic [3:0] fxRspNzcv, fxCmd, fxSr;
  logic [35:0] fxAluOut;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0]  mSr;
  logic        mLast, mIssue, mRsp, mS, mCin, mRspId;
  logic [3:0]  mCmd, mNzcv;
  logic [31:0] mVal1, mVal2, mRes;
  logic        acc0, acc1, seen0, seen1;

  always #5 clk = ~clk;

  // Reference ALU: {result, N, Z, C, V}. Unsupported commands return garbage
  // on purpose, so the arbiter has to mask them.
  function automatic logic [35:0] aluCompute(input logic [3:0] cmd, input logic [31:0] a,
                                             input logic [31:0] b, input logic cin);
    logic [32:0] w;
    logic [31:0] r;
    logic c, v;
    c = cin;
    v = 1'b0;
    r = 32'h0;
    case (cmd)
      4'b0001: r = b;
      4'b1001: r = ~b;
      4'b0110: r = a & b;
      4'b0111: r = a | b;
      4'b1000: r = a ^ b;
      4'b0010, 4'b0011: begin
        w = {1'b0, a} + {1'b0, b} + {32'b0, (cmd == 4'b0011) ? cin : 1'b0};
        r = w[31:0];
        c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0100, 4'b0101: begin
        w = {1'b0, a} - {1'b0, b} - {32'b0, (cmd == 4'b0101) ? ~cin : 1'b0};
        r = w[31:0];
        c = ~w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: return {a ^ b ^ 32'hDEADBEEF, 4'b1111};
    endcase
    return {r, r[31], (r == 32'h0), c, v};
  endfunction

  assign aluOut = aluCompute(alu_cmd, alu_val1, alu_val2, alu_c_in);
  assign {alu_result, alu_n, alu_z, alu_c, alu_v} = aluOut;
  assign fxAluOut = aluCompute(fxCmd, fxVal1, fxVal2, fxCIn);

  alu_share_arbiter #(.DATA_W(32), .PRIO_FIXED(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req0_val1(req0_val1), .req0_val2(req0_val2), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .req1_val1(req1_val1), .req1_val2(req1_val2), .req1_s(req1_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_nzcv(rsp_nzcv),
    .alu_cmd(alu_cmd), .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_c_in(alu_c_in),
    .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .sr_nzcv(sr_nzcv), .busy(busy)
  );

  alu_share_arbiter #(.DATA_W(32), .PRIO_FIXED(1'b1)) dutFixed (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fxReq0Ready), .req0_cmd(req0_cmd),
    .req0_val1(req0_val1), .req0_val2(req0_val2), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(fxReq1Ready), .req1_cmd(req1_cmd),
    .req1_val1(req1_val1), .req1_val2(req1_val2), .req1_s(req1_s),
    .rsp_valid(fxRspValid), .rsp_ready(rsp_ready), .rsp_id(fxRspId),
    .rsp_result(fxRspResult), .rsp_nzcv(fxRspNzcv),
    .alu_cmd(fxCmd), .alu_val1(fxVal1), .alu_val2(fxVal2), .alu_c_in(fxCIn),
    .alu_result(fxAluOut[35:4]), .alu_n(fxAluOut[3]), .alu_z(fxAluOut[2]),
    .alu_c(fxAluOut[1]), .alu_v(fxAluOut[0]),
    .sr_nzcv(fxSr), .busy(fxBusy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mSr = 4'h0; mLast = 1'b1; mIssue = 1'b0; mRsp = 1'b0;
    mCmd = 4'h0; mVal1 = 32'h0; mVal2 = 32'h0; mS = 1'b0; mCin = 1'b0;
    mRes = 32'h0; mNzcv = 4'h0; mRspId = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
  endtask

  // One clock: check at the falling edge, advance the model for the coming
  // rising edge, and return just after that edge.
  task automatic tick();
    logic opp, pick1, exp0, exp1, cv, supported;
    logic [35:0] ar;
    @(negedge clk);
    opp = !mIssue && (!mRsp || rsp_ready);
    pick1 = (req0_valid && req1_valid) ? !mLast : req1_valid;
    exp0 = opp && (req0_valid || req1_valid) && !pick1;
    exp1 = opp && (req0_valid || req1_valid) && pick1;
    seen0 = req0_ready;
    seen1 = req1_ready;
    checkOutput("req0Ready", req0_ready, exp0);
    checkOutput("req1Ready", req1_ready, exp1);
    checkOutput("busy", busy, mIssue || mRsp);
    checkOutput("rspValid", rsp_valid, mRsp);
    checkOutput("srNzcv", sr_nzcv, mSr);
    checkOutput("aluOps", {alu_cmd, alu_c_in, alu_val1, alu_val2}, {mCmd, mCin, mVal1, mVal2});
    if (mRsp) begin
      checkOutput("rspResult", rsp_result, mRes);
      checkOutput("rspNzcvId", {rsp_nzcv, rsp_id}, {mNzcv, mRspId});
    end
    if (req0_valid) checkOutput("fxNoReq1", fxReq1Ready, 1'b0);
    checkOutput("fxOneHot", fxReq0Ready & fxReq1Ready, 1'b0);

    acc0 = exp0;
    acc1 = exp1;
    if (mRsp && rsp_ready) mRsp = 1'b0;
    if (mIssue) begin
      supported = (mCmd >= 4'd1) && (mCmd <= 4'd9);
      cv = (mCmd >= 4'd2) && (mCmd <= 4'd5);
      if (supported) begin
        ar = aluCompute(mCmd, mVal1, mVal2, mCin);
        mRes = ar[35:4];
        mNzcv = ar[3:0];
        if (mS) mSr = {ar[3], ar[2], cv ? ar[1] : mSr[1], cv ? ar[0] : mSr[0]};
      end else begin
        mRes = 32'h0;
        mNzcv = mSr;
      end
      mIssue = 1'b0;
      mRsp = 1'b1;
    end
    if (exp0 || exp1) begin
      mCmd  = exp1 ? req1_cmd  : req0_cmd;
      mVal1 = exp1 ? req1_val1 : req0_val1;
      mVal2 = exp1 ? req1_val2 : req0_val2;
      mS    = exp1 ? req1_s    : req0_s;
      mRspId = exp1;
      mCin = mSr[1];
      mLast = exp1;
      mIssue = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int who, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic s);
    if (who == 0) begin
      req0_valid = 1'b1; req0_cmd = cmd; req0_val1 = a; req0_val2 = b; req0_s = s;
    end else begin
      req1_valid = 1'b1; req1_cmd = cmd; req1_val1 = a; req1_val2 = b; req1_s = s;
    end
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic randReq(input int who);
    setReq(who, 4'($urandom_range(0, 15)), randOperand(), randOperand(), 1'($urandom_range(0, 1)));
  endtask

  // Random traffic: keep an unaccepted op stable, occasionally drop it, and
  // offer fresh ops after acceptance.
  task automatic applyStimulus();
    if (acc0 || !req0_valid) begin
      if ($urandom_range(0, 9) < 6) randReq(0); else req0_valid = 1'b0;
    end else if ($urandom_range(0, 9) == 0) req0_valid = 1'b0;
    if (acc1 || !req1_valid) begin
      if ($urandom_range(0, 9) < 6) randReq(1); else req1_valid = 1'b0;
    end else if ($urandom_range(0, 9) == 0) req1_valid = 1'b0;
    rsp_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic drainIdle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) tick();
    checkOutput("drainIdle", busy, 1'b0);
  endtask

  initial begin
    int grants;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_cmd = 4'h0; req0_val1 = 32'h0; req0_val2 = 32'h0; req0_s = 1'b0;
    req1_valid = 1'b0; req1_cmd = 4'h0; req1_val1 = 32'h0; req1_val2 = 32'h0; req1_s = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstRspValid", rsp_valid, 1'b0);
    checkOutput("rstSr", sr_nzcv, 4'h0);
    checkOutput("rstAluCmd", alu_cmd, 4'h0);
    rst_n = 1'b1;

    // Signed overflow on ADD with a two-cycle response latency.
    rsp_ready = 1'b1;
    setReq(0, C_ADD, 32'h7FFFFFFF, 32'h1, 1'b1);
    tick();
    req0_valid = 1'b0;
    tick();
    checkOutput("addLatency", rsp_valid, 1'b1);
    checkOutput("addOvRes", rsp_result, 32'h80000000);
    checkOutput("addOvNzcv", rsp_nzcv, 4'b1001);
    checkOutput("addOvSr", sr_nzcv, 4'b1001);
    tick();

    // Carry chain: ADD sets C, then an ADC issued back-to-back consumes it.
    setReq(0, C_ADD, 32'hFFFFFFFF, 32'h1, 1'b1);
    tick();
    setReq(0, C_ADC, 32'h0, 32'h0, 1'b0);
    tick();
    checkOutput("carrySr", sr_nzcv, 4'b0110);
    tick();
    req0_valid = 1'b0;
    checkOutput("adcCin", alu_c_in, 1'b1);
    tick();
    checkOutput("adcRes", rsp_result, 32'h1);
    tick();

    // A flag-setting MOV leaves C untouched in the SR.
    setReq(0, C_MOV, 32'h5, 32'h0, 1'b1);
    tick();
    req0_valid = 1'b0;
    tick();
    checkOutput("movNzcv", rsp_nzcv, 4'b0110);
    checkOutput("movSr", sr_nzcv, 4'b0110);
    tick();

    // An unsupported command returns zero and leaves the SR alone even with s=1.
    setReq(1, 4'hF, 32'h3, 32'h4, 1'b1);
    tick();
    req1_valid = 1'b0;
    tick();
    checkOutput("badRes", rsp_result, 32'h0);
    checkOutput("badNzcvId", {rsp_nzcv, rsp_id}, {4'b0110, 1'b1});
    checkOutput("badSr", sr_nzcv, 4'b0110);
    tick();

    // Both requesters always valid: alternating grants, one every two cycles.
    setReq(0, C_ADD, 32'h1, 32'h2, 1'b0);
    setReq(1, C_SUB, 32'h9, 32'h4, 1'b0);
    grants = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (seen0 || seen1) begin
        checkOutput("rrGrant", seen1, (grants % 2) == 1);
        grants++;
      end
      if (acc0) randReq(0);
      if (acc1) randReq(1);
    end
    checkOutput("rrCount", grants, 8);
    drainIdle();

    // Backpressure: the response is held, no grants occur, then req1 wins.
    rsp_ready = 1'b0;
    setReq(0, C_SUB, 32'h10, 32'h20, 1'b1);
    tick();
    req0_valid = 1'b0;
    tick();
    setReq(0, C_ADD, 32'h5, 32'h6, 1'b0);
    setReq(1, C_ADD, 32'h7, 32'h8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bpReadys", {seen0, seen1}, 2'b00);
      checkOutput("bpBusy", busy, 1'b1);
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput("bpGrant1", {seen0, seen1}, 2'b01);
    drainIdle();

    // Asynchronous reset in the middle of a held response.
    rsp_ready = 1'b0;
    setReq(0, C_ADD, 32'hFFFFFFFF, 32'h1, 1'b1);
    tick();
    req0_valid = 1'b0;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstRspValid", rsp_valid, 1'b0);
    checkOutput("midRstSr", sr_nzcv, 4'h0);
    checkOutput("midRstBusy", busy, 1'b0);
    modelReset();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    setReq(0, C_ADD, 32'h2, 32'h3, 1'b1);
    setReq(1, C_ADD, 32'h4, 32'h5, 1'b1);
    tick();
    checkOutput("rstFirstGrant", {seen0, seen1}, 2'b10);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus();
      tick();
    end
    drainIdle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
